// File: rtl/inst_sram_resp_if.sv
// Fetch-side and backing-memory signals of the instruction SRAM responder.
// slave is the responder's view; master is the requester/memory side.
interface inst_sram_resp_if;
   logic        sram_inst_ena;
   logic [31:0] sram_inst_addr;
   logic [31:0] sram_inst_rdata_1;
   logic [31:0] sram_inst_rdata_2;
   logic        sram_inst_ok_1;
   logic        sram_inst_ok_2;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  sram_inst_ena, sram_inst_addr, mem_ack, mem_rdata,
      output sram_inst_rdata_1, sram_inst_rdata_2, sram_inst_ok_1, sram_inst_ok_2,
             mem_req, mem_addr
   );

   modport master (
      output sram_inst_ena, sram_inst_addr, mem_ack, mem_rdata,
      input  sram_inst_rdata_1, sram_inst_rdata_2, sram_inst_ok_1, sram_inst_ok_2,
             mem_req, mem_addr
   );
endinterface

// File: rtl/inst_sram_resp.sv
// Instruction-fetch responder: turns a held fetch request into one or two word reads.
// Define INST_SRAM_RESP_PAIR_EN to compile in the second-word (RD2) fetch.
//
// state | meaning
// IDLE  | waiting for a fetch request; ok pulses are driven here
// RD1   | reading the word at the captured address
// RD2   | reading the word at captured address + 4 (pair build only)
// DRAIN | flushed; waiting out the outstanding read before returning to IDLE
module inst_sram_resp #(
   parameter int PAGE_BITS = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   output logic            busy,
   inst_sram_resp_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD1, RD2, DRAIN} state_t;

   if (PAGE_BITS < 3 || PAGE_BITS > 32) begin : g_bad_page
      $error("inst_sram_resp: PAGE_BITS must be in 3..32");
   end

   state_t      state, state_nx;
   logic        req_q, req_nx;
   logic [31:0] addr_q, addr_nx;
   logic        ok1_q, ok1_nx;
   logic [31:0] rd1_q, rd1_nx;
`ifdef INST_SRAM_RESP_PAIR_EN
   logic        ok2_q, ok2_nx;
   logic [31:0] rd2_q, rd2_nx;
   logic [31:0] word1_q, word1_nx;
   logic        page_end;

   // The second word would fall into the next page, so stop after one.
   assign page_end = &addr_q[PAGE_BITS-1:2];
`endif

   always_comb begin
      state_nx = state;
      req_nx   = req_q;
      addr_nx  = addr_q;
      ok1_nx   = 1'b0;
      rd1_nx   = rd1_q;
`ifdef INST_SRAM_RESP_PAIR_EN
      ok2_nx   = 1'b0;
      rd2_nx   = rd2_q;
      word1_nx = word1_q;
`endif
      case (state)
         IDLE: begin
            // ok_1 high means the requester has not yet seen completion and still holds ena.
            if (bus.sram_inst_ena && !flush && !ok1_q) begin
               state_nx = RD1;
               req_nx   = 1'b1;
               addr_nx  = bus.sram_inst_addr & 32'hFFFF_FFFC;
            end
         end
         RD1: begin
            if (bus.mem_ack) begin
               if (flush) begin
                  state_nx = IDLE;
                  req_nx   = 1'b0;
               end
`ifdef INST_SRAM_RESP_PAIR_EN
               else if (!page_end) begin
                  state_nx = RD2;
                  addr_nx  = addr_q + 32'd4;
                  word1_nx = bus.mem_rdata;
               end
`endif
               else begin
                  state_nx = IDLE;
                  req_nx   = 1'b0;
                  ok1_nx   = 1'b1;
                  rd1_nx   = bus.mem_rdata;
`ifdef INST_SRAM_RESP_PAIR_EN
                  rd2_nx   = '0;
`endif
               end
            end else if (flush) begin
               state_nx = DRAIN;
            end
         end
`ifdef INST_SRAM_RESP_PAIR_EN
         RD2: begin
            if (bus.mem_ack) begin
               state_nx = IDLE;
               req_nx   = 1'b0;
               if (!flush) begin
                  ok1_nx = 1'b1;
                  ok2_nx = 1'b1;
                  rd1_nx = word1_q;
                  rd2_nx = bus.mem_rdata;
               end
            end else if (flush) begin
               state_nx = DRAIN;
            end
         end
`endif
         DRAIN: begin
            if (bus.mem_ack) begin
               state_nx = IDLE;
               req_nx   = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            req_nx   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         ok1_q   <= 1'b0;
         rd1_q   <= '0;
`ifdef INST_SRAM_RESP_PAIR_EN
         ok2_q   <= 1'b0;
         rd2_q   <= '0;
         word1_q <= '0;
`endif
      end else begin
         state   <= state_nx;
         req_q   <= req_nx;
         addr_q  <= addr_nx;
         ok1_q   <= ok1_nx;
         rd1_q   <= rd1_nx;
`ifdef INST_SRAM_RESP_PAIR_EN
         ok2_q   <= ok2_nx;
         rd2_q   <= rd2_nx;
         word1_q <= word1_nx;
`endif
      end
   end

   assign busy                  = (state != IDLE);
   assign bus.mem_req           = req_q;
   assign bus.mem_addr          = addr_q;
   assign bus.sram_inst_ok_1    = ok1_q;
   assign bus.sram_inst_rdata_1 = rd1_q;
`ifdef INST_SRAM_RESP_PAIR_EN
   assign bus.sram_inst_ok_2    = ok2_q;
   assign bus.sram_inst_rdata_2 = rd2_q;
`else
   assign bus.sram_inst_ok_2    = 1'b0;
   assign bus.sram_inst_rdata_2 = '0;
`endif
endmodule
